// File: rtl/pio_out_pkg.sv
// pio_out_pkg: register addresses and pulse engine state shared by pio_out_ctrl and its timer
package pio_out_pkg;
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd2;
    localparam logic [2:0] ADDR_CLEAR     = 3'd3;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
    localparam logic [2:0] ADDR_PULSE_GO  = 3'd5;
    localparam logic [2:0] ADDR_STATUS    = 3'd6;
    typedef enum logic {IDLE, PULSE} pulse_state_e;
endpackage

// File: rtl/pio_pulse_timer.sv
// pio_pulse_timer: one-shot pulse length counter
//   go   : start request, accepted only when idle
//   len  : pulse length in cycles, 0 treated as 1
//   busy : high while a pulse is running
//   done : high in the last pulse cycle
module pio_pulse_timer
    import pio_out_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done
);
    pulse_state_e state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (go) begin
                state_d = PULSE;
                cnt_d   = (len == '0) ? LEN_W'(1) : len;
            end
        end else begin
            cnt_d = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
    end

    always_comb begin
        busy = (state_q == PULSE);
        done = busy && (cnt_q == LEN_W'(1));
    end
endmodule

// File: rtl/pio_out_ctrl.sv
// pio_out_ctrl: Avalon-MM parallel output port with set/clear and timed pulse inversion
//   clk, reset          : clock and synchronous active-high reset
//   address, chipselect,
//   write_n, writedata  : slave write interface
//   readdata            : combinational read data, zero-extended
//   out_port            : registered output pins, data XOR active pulse mask
module pio_out_ctrl
    import pio_out_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               LEN_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0] data_q, data_d, pmask_q, pmask_d, out_q, out_d, wd;
    logic [LEN_W-1:0] len_q, len_d;
    logic             wr, go, busy, done;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign out_port  = out_q;

    pio_pulse_timer #(.LEN_W(LEN_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .len   (len_q),
        .busy  (busy),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= RESET_VALUE;
            len_q   <= '0;
            pmask_q <= '0;
            out_q   <= RESET_VALUE;
        end else begin
            data_q  <= data_d;
            len_q   <= len_d;
            pmask_q <= pmask_d;
            out_q   <= out_d;
        end
    end

    // out_d uses the next-cycle data and mask so the output register
    // tracks data writes and pulse start/end on the same edge
    always_comb begin
        data_d  = !wr                     ? data_q :
                  address == ADDR_DATA    ? wd :
                  address == ADDR_SET     ? (data_q | wd) :
                  address == ADDR_CLEAR   ? (data_q & ~wd) : data_q;
        len_d   = (wr && address == ADDR_PULSE_LEN) ? writedata[LEN_W-1:0] : len_q;
        go      = wr && address == ADDR_PULSE_GO && wd != '0;
        pmask_d = (go && !busy) ? wd : done ? '0 : pmask_q;
        out_d   = data_d ^ pmask_d;
    end

    always_comb begin
        readdata = address == ADDR_DATA      ? 32'(data_q) :
                   address == ADDR_PULSE_LEN ? 32'(len_q) :
                   address == ADDR_STATUS    ? 32'({pmask_q, busy}) : '0;
    end
endmodule

// File: tb/tb_pio_out_ctrl.sv
// tb_pio_out_ctrl: scoreboard bench for pio_out_ctrl against a cycle-level behavioural model
module tb_pio_out_ctrl;
    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write_n = 1'b1;
    logic [2:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    always #5 clk = ~clk;

    pio_out_ctrl #(.WIDTH(8), .RESET_VALUE(8'h00), .LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [31:0] rd;
        logic [7:0]  out;
    } exp_t;

    exp_t sb[$];
    int total = 0, bad = 0, cyc = 0;

    // model: pulse is "m_rem cycles of inversion still to show"
    logic [7:0]  m_data, m_pmask;
    logic [15:0] m_len;
    int          m_rem;

    function automatic logic [31:0] m_read(logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd4:    return {16'd0, m_len};
            3'd6:    return {23'd0, m_pmask, m_rem > 0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_step(bit rst, bit cs, bit wn, logic [2:0] a, logic [31:0] d);
        bit was_busy;
        if (rst) begin
            m_data = 8'h00; m_len = 16'd0; m_rem = 0; m_pmask = 8'h00;
            return;
        end
        was_busy = m_rem > 0;
        if (was_busy) begin
            m_rem--;
            if (m_rem == 0) m_pmask = 8'h00;
        end
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = d[7:0];
                3'd2: m_data = m_data | d[7:0];
                3'd3: m_data = m_data & ~d[7:0];
                3'd4: m_len  = d[15:0];
                3'd5: if (!was_busy && d[7:0] != 8'h00) begin
                    m_pmask = d[7:0];
                    m_rem   = (m_len == 16'd0) ? 1 : int'(m_len);
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(bit rst, bit cs, bit wn, logic [2:0] a, logic [31:0] d);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
        sb.push_back('{cyc, a, m_read(a), m_data ^ (m_rem > 0 ? m_pmask : 8'h00)});
        @(posedge clk); #1;
        cyc++;
        m_step(rst, cs, wn, a, d);
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d); cycle(0, 1, 0, a, d); endtask
    task automatic rd(logic [2:0] a);                 cycle(0, 1, 1, a, 32'hDEAD_BEEF); endtask
    task automatic rst_cyc();                         cycle(1, 0, 1, 3'd0, 32'd0); endtask

    initial forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (readdata !== e.rd) begin
                bad++;
                $display("FAIL cyc%0d readdata@addr%0d got %h want %h", e.cyc, e.addr, readdata, e.rd);
            end
            total++;
            if (out_port !== e.out) begin
                bad++;
                $display("FAIL cyc%0d out_port got %h want %h", e.cyc, out_port, e.out);
            end
        end
    end

    int          r;
    logic [2:0]  a;
    logic [31:0] d;

    initial begin
        @(posedge clk); #1;
        m_step(1, 0, 1, 3'd0, 32'd0);
        rst_cyc();
        rd(3'd0); wr(3'd0, 32'hFFFF_FFA5); rd(3'd0);
        wr(3'd2, 32'h0A); rd(3'd0); wr(3'd3, 32'h81); rd(3'd0); rd(3'd1); rd(3'd7);
        wr(3'd4, 32'd3); wr(3'd0, 32'h00); wr(3'd5, 32'h01);
        repeat (5) rd(3'd6);
        wr(3'd4, 32'd0); wr(3'd5, 32'h80); rd(3'd6); rd(3'd6); wr(3'd5, 32'h00); rd(3'd6);
        wr(3'd4, 32'd10); wr(3'd5, 32'h01); rd(3'd6); wr(3'd5, 32'h02); rd(3'd6); wr(3'd2, 32'h04);
        repeat (9) rd(3'd6);
        wr(3'd4, 32'd10); wr(3'd5, 32'h0F);
        repeat (4) rd(3'd6);
        rst_cyc(); rd(3'd6); rd(3'd0); rd(3'd6); rd(3'd4);
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd4) d = (d & 32'hFFFF_0000) | $urandom_range(0, 12);
            if (a == 3'd5 && $urandom_range(0, 4) == 0) d = d & 32'hFFFF_FF00;
            cycle(r < 2, r < 80, r >= 55, a, d);
        end
        rd(3'd6);
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
